bias_sweep_controller: RTL and testbench
========================================

Name: bias_sweep_controller

Overview:
- Sequences the single-port LSTM gate bias memory: bulk-loads HIDDEN_SIZE bias words from an upstream stream, then streams them out one per hidden unit to the gate accumulator on request.
- Arbitrates the memory between the loader (write side) and the compute sweep (read side).
- Absorbs the memory's 1-cycle registered read latency behind a valid/ready output handshake.

Parameters:
- DATA_WIDTH, 16, bias word width (signed Q-format, passed through unmodified)
- ADDR_WIDTH, 7, bias memory address width
- HIDDEN_SIZE, 100, number of biases per sweep/load; must be ≤ 2^ADDR_WIDTH − BASE_ADDR
- BASE_ADDR, 0, first memory address used

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse requesting a read sweep
- load_valid  in  1  loader word valid
- load_data  in  DATA_WIDTH  loader word (signed)
- load_ready  out  1  loader word accepted when load_valid & load_ready
- mem_write_enable  out  1  to memory write_enable
- mem_write_address  out  ADDR_WIDTH  to memory write_address
- mem_write_data  out  DATA_WIDTH  to memory write_data
- mem_read_enable  out  1  to memory read_enable
- mem_read_pointer  out  ADDR_WIDTH  to memory read pointer
- mem_read_data  in  DATA_WIDTH  from memory registered read output (READ_BURST=1)
- bias_out  out  DATA_WIDTH  combinational pass-through of mem_read_data
- bias_index  out  ADDR_WIDTH  hidden-unit index (0..HIDDEN_SIZE−1) of bias_out
- bias_valid  out  1  bias_out valid
- bias_ready  in  1  consumer accepts beat when bias_valid & bias_ready
- busy  out  1  high in LOAD or READ
- load_done  out  1  one-cycle pulse after final load word is written
- sweep_done  out  1  one-cycle pulse after final bias beat is accepted

Behaviour:
- Reset: state=IDLE; counters, start_pending and all outputs 0 (bias_out follows mem_read_data). Memory contents untouched. Reset mid-LOAD or mid-READ aborts immediately; no done pulse.
- State IDLE:
  - load_ready=1.
  - load_valid → write word at BASE_ADDR in the same cycle, wr_cnt=1, go LOAD.
  - Else start or start_pending → clear pending, go READ.
  - Load has priority: if start and load_valid coincide, the write proceeds and start_pending is set.
- State LOAD:
  - load_ready=1. Each accepted word drives mem_write_enable=1 in the same cycle, mem_write_address=BASE_ADDR+wr_cnt, mem_write_data=load_data; then wr_cnt increments.
  - On the HIDDEN_SIZE-th word: go DONE_L, wr_cnt=0.
  - start during LOAD sets start_pending.
  - Gaps in load_valid are allowed.
- State DONE_L: load_done=1 for one cycle, load_ready=0, then go IDLE. A pending start launches READ from IDLE on the following cycle.
- State READ: load_ready=0, load_valid ignored, start ignored.
  - Issue condition: rd_cnt<HIDDEN_SIZE and (!bias_valid or bias_ready).
  - On issue: mem_read_enable=1, mem_read_pointer=BASE_ADDR+rd_cnt, rd_cnt++, and bias_index takes the issued index.
  - bias_valid (registered):
    - set the cycle after an issue;
    - stays set while the beat is not accepted;
    - clears after acceptance when no new issue occurred.
  - Memory holds its output while mem_read_enable=0, so a stalled beat stays stable. Issue and accept in the same cycle give full throughput of 1 beat/cycle.
  - When rd_cnt==HIDDEN_SIZE and the last beat is accepted: go DONE_R.
- State DONE_R: sweep_done=1 for one cycle, bias_valid=0, then IDLE.
- Mutual exclusion: mem_write_enable and mem_read_enable are never both high.
- Address arithmetic: unsigned ADDR_WIDTH, no wrap within legal parameters.
- Latency:
  - start (IDLE) → first bias_valid = 2 cycles: READ entry, issue, valid.
  - Unstalled sweep: HIDDEN_SIZE+3 cycles from start to sweep_done.

Test Plan:
- Load: stream 100 words 0x0000..0x0063 with no gaps → 100 writes to addresses 0..99 with matching data, load_done pulses on cycle 101, then IDLE.
- Sweep with bias_ready tied 1: start → bias_valid on cycle +2, 100 consecutive beats with bias_index 0..99 and data equal to memory contents, sweep_done once, no write strobes.
- Backpressure: bias_ready toggling 1,0,0,1… → no beat dropped or duplicated, bias_out/bias_index stable while stalled, no read issued while valid & !ready.
- Collision: start and load_valid high together in IDLE → load completes, then load_done, then the sweep starts automatically; the reads return the newly loaded data.
- Ignored inputs: start pulse mid-READ and load_valid mid-READ → no second sweep, load_ready=0, memory unchanged.
- Reset mid-sweep at beat 37: assert rst one cycle → all outputs 0, state IDLE, no sweep_done; a following start gives a full sweep from index 0.

Source files
------------

// File: rtl/bias_sweep_controller_if.sv
// Handshake and memory bundle for the bias sweep controller.
// master: controller side; slave: loader, bias memory and gate accumulator.
interface bias_sweep_controller_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
) ();
    // loader stream
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    // single-port bias memory
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_read_enable;
    logic [ADDR_WIDTH-1:0] mem_read_pointer;
    logic [DATA_WIDTH-1:0] mem_read_data;
    // bias beats to the gate accumulator
    logic [DATA_WIDTH-1:0] bias_out;
    logic [ADDR_WIDTH-1:0] bias_index;
    logic                  bias_valid;
    logic                  bias_ready;

    modport master (
        input  load_valid,
        input  load_data,
        output load_ready,
        output mem_write_enable,
        output mem_write_address,
        output mem_write_data,
        output mem_read_enable,
        output mem_read_pointer,
        input  mem_read_data,
        output bias_out,
        output bias_index,
        output bias_valid,
        input  bias_ready
    );

    modport slave (
        output load_valid,
        output load_data,
        input  load_ready,
        input  mem_write_enable,
        input  mem_write_address,
        input  mem_write_data,
        input  mem_read_enable,
        input  mem_read_pointer,
        output mem_read_data,
        input  bias_out,
        input  bias_index,
        input  bias_valid,
        output bias_ready
    );
endinterface

// File: rtl/bias_sweep_controller.sv
// Bias memory sequencer: bulk-loads HIDDEN_SIZE words, then sweeps them out.
// Ports: clk, rst (sync, active high), start (sweep request pulse),
// busy (LOAD or READ), load_done / sweep_done (one-cycle pulses),
// bus (master): loader stream, memory write/read port, bias beat stream.
module bias_sweep_controller #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 7,
    parameter int HIDDEN_SIZE = 100,
    parameter int BASE_ADDR   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic load_done,
    output logic sweep_done,
    bias_sweep_controller_if.master bus
);

    // One extra bit so the read counter can hold HIDDEN_SIZE itself.
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] BASE =
        ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_WR =
        ADDR_WIDTH'(HIDDEN_SIZE - 1);
    localparam logic [CNT_W-1:0] SWEEP_LEN =
        CNT_W'(HIDDEN_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DONE_L,
        READ,
        DONE_R
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [CNT_W-1:0]      rd_cnt;
    logic                  start_pending;
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] index_q;

    logic accepting;
    logic write_fire;
    logic last_word;
    logic issue;
    logic accept;
    logic sweep_end;

    // Strobes are gated by rst so a reset cycle never touches memory.
    always_comb begin
        accepting  = !rst && (state == IDLE || state == LOAD);
        write_fire = accepting && bus.load_valid;
        last_word  = (wr_cnt == LAST_WR);
        accept     = valid_q && bus.bias_ready;
        // A new read only when the output register is free or draining.
        issue      = !rst && (state == READ) &&
                     (rd_cnt < SWEEP_LEN) &&
                     (!valid_q || bus.bias_ready);
        sweep_end  = (state == READ) &&
                     (rd_cnt == SWEEP_LEN) && accept;
    end

    assign bus.load_ready        = accepting;
    assign bus.mem_write_enable  = write_fire;
    assign bus.mem_write_address = write_fire ? BASE + wr_cnt : '0;
    assign bus.mem_write_data    = write_fire ? bus.load_data : '0;
    assign bus.mem_read_enable   = issue;
    assign bus.mem_read_pointer  =
        issue ? BASE + rd_cnt[ADDR_WIDTH-1:0] : '0;

    // Memory holds its output while not read, so a stalled
    // beat stays stable without a local data register.
    assign bus.bias_out   = bus.mem_read_data;
    assign bus.bias_valid = valid_q;
    assign bus.bias_index = index_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            start_pending <= 1'b0;
            valid_q       <= 1'b0;
            index_q       <= '0;
            busy          <= 1'b0;
            load_done     <= 1'b0;
            sweep_done    <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            sweep_done <= 1'b0;

            // Output register: the issued index lands with its data.
            if (issue) begin
                valid_q <= 1'b1;
                index_q <= rd_cnt[ADDR_WIDTH-1:0];
                rd_cnt  <= rd_cnt + 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end

            // Loader words are handled alike in IDLE and LOAD.
            if (write_fire) begin
                if (last_word) begin
                    wr_cnt    <= '0;
                    state     <= DONE_L;
                    busy      <= 1'b0;
                    load_done <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                    state  <= LOAD;
                    busy   <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        // Load wins; remember the sweep request.
                        if (start) start_pending <= 1'b1;
                    end else if (start || start_pending) begin
                        start_pending <= 1'b0;
                        state         <= READ;
                        busy          <= 1'b1;
                    end
                end
                LOAD: begin
                    if (start) start_pending <= 1'b1;
                end
                DONE_L: begin
                    if (start) start_pending <= 1'b1;
                    state <= IDLE;
                end
                READ: begin
                    if (sweep_end) begin
                        state      <= DONE_R;
                        busy       <= 1'b0;
                        sweep_done <= 1'b1;
                        rd_cnt     <= '0;
                    end
                end
                DONE_R: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_sweep_controller.sv
// Bench for bias_sweep_controller: vector table, directed sequences,
// random traffic against a memory/beat-order reference model.
module tb_bias_sweep_controller;

    localparam int DW   = 16;
    localparam int AW   = 7;
    localparam int H    = 100;
    localparam int BASE = 0;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic load_done;
    logic sweep_done;

    bias_sweep_controller_if #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) bus ();

    bias_sweep_controller #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .HIDDEN_SIZE(H),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .load_done (load_done),
        .sweep_done(sweep_done),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read single-port memory (READ_BURST=1).
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata;
    always @(posedge clk) begin
        if (bus.mem_write_enable)
            mem[bus.mem_write_address] <= bus.mem_write_data;
        if (bus.mem_read_enable)
            rdata <= mem[bus.mem_read_pointer];
    end
    assign bus.mem_read_data = rdata;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    // Reference model: expected memory image and stream positions.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            mon_en = 0;
    int            exp_wr = 0;
    int            exp_beat = 0;
    bit            ld_exp = 0;
    bit            sd_exp = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_out;
    logic [AW-1:0] prev_idx;
    int            beats_total = 0;
    int            sweeps_total = 0;
    int            writes_total = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("load_done", 32'(load_done), 32'(ld_exp));
            check("sweep_done", 32'(sweep_done), 32'(sd_exp));
            check("mutex",
                  32'(bus.mem_write_enable && bus.mem_read_enable),
                  32'(0));
            if (prev_stall) begin
                check("stall_valid", 32'(bus.bias_valid), 32'(1));
                check("stall_out", 32'(bus.bias_out), 32'(prev_out));
                check("stall_idx", 32'(bus.bias_index), 32'(prev_idx));
            end
            if (bus.bias_valid && !bus.bias_ready)
                check("stall_read", 32'(bus.mem_read_enable), 32'(0));
            if (exp_beat > 0) begin
                check("sweep_lr", 32'(bus.load_ready), 32'(0));
                check("sweep_we", 32'(bus.mem_write_enable), 32'(0));
            end
            ld_exp = 0;
            sd_exp = 0;
            if (rst) begin
                exp_wr     = 0;
                exp_beat   = 0;
                prev_stall = 0;
            end else begin
                check("wr_en", 32'(bus.mem_write_enable),
                      32'(bus.load_valid && bus.load_ready));
                if (bus.load_valid && bus.load_ready) begin
                    check("wr_addr", 32'(bus.mem_write_address),
                          32'(BASE + exp_wr));
                    check("wr_data", 32'(bus.mem_write_data),
                          32'(bus.load_data));
                    ref_mem[BASE + exp_wr] = bus.load_data;
                    writes_total++;
                    exp_wr++;
                    if (exp_wr == H) begin
                        exp_wr = 0;
                        ld_exp = 1;
                    end
                end
                if (bus.bias_valid && bus.bias_ready) begin
                    check("beat_idx", 32'(bus.bias_index),
                          32'(exp_beat));
                    check("beat_data", 32'(bus.bias_out),
                          32'(ref_mem[BASE + exp_beat]));
                    beats_total++;
                    exp_beat++;
                    if (exp_beat == H) begin
                        exp_beat = 0;
                        sd_exp   = 1;
                        sweeps_total++;
                    end
                end
                prev_stall = bus.bias_valid && !bus.bias_ready;
                prev_out   = bus.bias_out;
                prev_idx   = bus.bias_index;
            end
        end
    end

    typedef struct {
        int rst, st, lv, ld, br;
        int lr, we, wa, wd, re, rp, bv, bi, bu, ldn, sdn;
    } vec_t;

    vec_t tbl [14];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, input int mode,
                             output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            next_cycle();
            if (mode == 1) bus.bias_ready = (n % 3 == 0);
            @(negedge clk);
            n++;
            if (sweep_done) return;
        end
        fail_now("sweep_wait");
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            if (exp_beat >= n) return;
        end
        fail_now("beat_wait");
    endtask

    int n;
    int b0;
    int s0;
    int w0;

    initial begin
        //   rst st lv ld      br  lr we wa wd      re rp bv bi bu ld sd
        tbl[0]  = '{0,0,0,0,     0, 1,0,0,0,     0,0,0,0,0,0,0};
        tbl[1]  = '{0,1,1,'h1111,0, 1,1,0,'h1111,0,0,0,0,0,0,0};
        tbl[2]  = '{0,0,0,0,     0, 1,0,0,0,     0,0,0,0,1,0,0};
        tbl[3]  = '{0,0,1,'h2222,0, 1,1,1,'h2222,0,0,0,0,1,0,0};
        tbl[4]  = '{1,0,0,0,     0, 0,0,0,0,     0,0,0,0,1,0,0};
        tbl[5]  = '{0,0,0,0,     0, 1,0,0,0,     0,0,0,0,0,0,0};
        tbl[6]  = '{0,0,0,0,     0, 1,0,0,0,     0,0,0,0,0,0,0};
        tbl[7]  = '{0,1,0,0,     0, 1,0,0,0,     0,0,0,0,0,0,0};
        tbl[8]  = '{0,0,0,0,     0, 0,0,0,0,     1,0,0,0,1,0,0};
        tbl[9]  = '{0,0,1,'h3333,0, 0,0,0,0,     0,0,1,0,1,0,0};
        tbl[10] = '{0,0,0,0,     1, 0,0,0,0,     1,1,1,0,1,0,0};
        tbl[11] = '{0,0,0,0,     0, 0,0,0,0,     0,0,1,1,1,0,0};
        tbl[12] = '{1,0,0,0,     0, 0,0,0,0,     0,0,1,1,1,0,0};
        tbl[13] = '{0,0,0,0,     0, 1,0,0,0,     0,0,0,0,0,0,0};

        rst = 1'b1;
        start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.bias_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1;

        // Cycle-exact vectors: collision, gap, reset abort, stall.
        for (int i = 0; i < 14; i++) begin
            next_cycle();
            rst            = tbl[i].rst[0];
            start          = tbl[i].st[0];
            bus.load_valid = tbl[i].lv[0];
            bus.load_data  = 16'(tbl[i].ld);
            bus.bias_ready = tbl[i].br[0];
            @(negedge clk);
            check($sformatf("t%0d_lr", i),
                  32'(bus.load_ready), tbl[i].lr);
            check($sformatf("t%0d_we", i),
                  32'(bus.mem_write_enable), tbl[i].we);
            check($sformatf("t%0d_wa", i),
                  32'(bus.mem_write_address), tbl[i].wa);
            check($sformatf("t%0d_wd", i),
                  32'(bus.mem_write_data), tbl[i].wd);
            check($sformatf("t%0d_re", i),
                  32'(bus.mem_read_enable), tbl[i].re);
            check($sformatf("t%0d_rp", i),
                  32'(bus.mem_read_pointer), tbl[i].rp);
            check($sformatf("t%0d_bv", i),
                  32'(bus.bias_valid), tbl[i].bv);
            check($sformatf("t%0d_bi", i),
                  32'(bus.bias_index), tbl[i].bi);
            check($sformatf("t%0d_busy", i), 32'(busy), tbl[i].bu);
            check($sformatf("t%0d_ldn", i),
                  32'(load_done), tbl[i].ldn);
            check($sformatf("t%0d_sdn", i),
                  32'(sweep_done), tbl[i].sdn);
        end

        // Gap-free load of 0..99.
        w0 = writes_total;
        for (int i = 0; i < H; i++) begin
            next_cycle();
            bus.load_valid = 1'b1;
            bus.load_data  = 16'(i);
        end
        next_cycle();
        bus.load_valid = 1'b0;
        @(negedge clk);
        check("load_done_pulse", 32'(load_done), 32'(1));
        check("done_l_lr", 32'(bus.load_ready), 32'(0));
        check("load_writes", 32'(writes_total - w0), 32'(H));
        next_cycle();
        @(negedge clk);
        check("idle_lr", 32'(bus.load_ready), 32'(1));
        check("idle_busy", 32'(busy), 32'(0));

        // Unstalled sweep, latency and length.
        b0 = beats_total;
        w0 = writes_total;
        next_cycle();
        start = 1'b1;
        bus.bias_ready = 1'b1;
        @(negedge clk);
        check("s_c0_bv", 32'(bus.bias_valid), 32'(0));
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check("s_c1_re", 32'(bus.mem_read_enable), 32'(1));
        check("s_c1_rp", 32'(bus.mem_read_pointer), 32'(0));
        check("s_c1_bv", 32'(bus.bias_valid), 32'(0));
        check("s_c1_busy", 32'(busy), 32'(1));
        next_cycle();
        @(negedge clk);
        check("s_c2_bv", 32'(bus.bias_valid), 32'(1));
        check("s_c2_bi", 32'(bus.bias_index), 32'(0));
        wait_done(400, 0, n);
        // start cycle through sweep_done cycle spans H+3 cycles
        check("sweep_len", 32'(n + 2), 32'(H + 2));
        check("sweep_beats", 32'(beats_total - b0), 32'(H));
        check("sweep_writes", 32'(writes_total - w0), 32'(0));

        // Backpressure 1,0,0,1,...
        b0 = beats_total;
        next_cycle();
        start = 1'b1;
        bus.bias_ready = 1'b0;
        next_cycle();
        start = 1'b0;
        wait_done(1000, 1, n);
        check("bp_beats", 32'(beats_total - b0), 32'(H));

        // Collision: start with first load word, sweep follows.
        b0 = beats_total;
        s0 = sweeps_total;
        next_cycle();
        bus.bias_ready = 1'b1;
        start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h8000;
        for (int i = 1; i < H; i++) begin
            next_cycle();
            start = 1'b0;
            bus.load_data = 16'(16'h8000 + i * 7);
        end
        next_cycle();
        bus.load_valid = 1'b0;
        @(negedge clk);
        check("col_load_done", 32'(load_done), 32'(1));
        wait_done(400, 0, n);
        check("col_sweeps", 32'(sweeps_total - s0), 32'(1));
        check("col_beats", 32'(beats_total - b0), 32'(H));

        // start and load_valid mid-READ are ignored.
        s0 = sweeps_total;
        w0 = writes_total;
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_beats(10);
        #1;
        start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h7777;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        bus.load_valid = 1'b0;
        wait_done(400, 0, n);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            @(negedge clk);
            check("ign_bv", 32'(bus.bias_valid), 32'(0));
            check("ign_busy", 32'(busy), 32'(0));
        end
        check("ign_sweeps", 32'(sweeps_total - s0), 32'(1));
        check("ign_writes", 32'(writes_total - w0), 32'(0));

        // Reset at beat 37, then a full sweep from index 0.
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_beats(37);
        #1;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_bv", 32'(bus.bias_valid), 32'(0));
        check("rst_bi", 32'(bus.bias_index), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_sdn", 32'(sweep_done), 32'(0));
        check("rst_re", 32'(bus.mem_read_enable), 32'(0));
        check("rst_lr", 32'(bus.load_ready), 32'(1));
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            check("rst_idle", 32'(busy), 32'(0));
        end
        b0 = beats_total;
        s0 = sweeps_total;
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_done(400, 0, n);
        check("rst_sweeps", 32'(sweeps_total - s0), 32'(1));
        check("rst_beats", 32'(beats_total - b0), 32'(H));

        // Random traffic; the monitor checks every cycle.
        s0 = sweeps_total;
        for (int k = 0; k < 4000; k++) begin
            next_cycle();
            rst            = ($urandom_range(999) == 0);
            start          = ($urandom_range(39) == 0);
            bus.load_valid = ($urandom_range(3) == 0);
            bus.load_data  = 16'($urandom);
            bus.bias_ready = ($urandom_range(1) == 1);
        end
        next_cycle();
        rst = 1'b0;
        start = 1'b0;
        bus.load_valid = 1'b0;
        @(negedge clk);
        check("rand_sweeps", 32'(sweeps_total > s0), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
